// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper move engine: phase table, FSM
// states, default ramp timing and the coil-pattern-to-phase lookup.
package stepper_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  localparam logic [3:0] PHASE_TABLE [0:7] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  localparam logic [3:0]  RESET_COIL       = 4'b1100;
  localparam logic [23:0] DEF_START_PERIOD = 24'd2_000_000;
  localparam logic [23:0] DEF_ACCEL_DEC    = 24'd50_000;

  // Unknown patterns resume from the two-coil phase 1 (1100).
  function automatic logic [2:0] pattern_to_index(input logic [3:0] pat);
    logic [2:0] idx;
    idx = 3'd1;
    for (int i = 0; i < 8; i++) begin
      if (PHASE_TABLE[i] == pat) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/stepper_move_step_ramp.sv
// Trapezoidal speed ramp: holds the current step period and the number of
// acceleration steps taken, and updates both on every step strobe.
module step_ramp #(
  parameter int                STEP_W       = 12,
  parameter int                DIV_W        = 24,
  parameter logic [DIV_W-1:0]  START_PERIOD = '0,
  parameter logic [DIV_W-1:0]  ACCEL_DEC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DIV_W-1:0]  load_period_i,
  input  logic              step_i,
  input  logic [STEP_W-1:0] rem_i,
  input  logic [DIV_W-1:0]  period_l_i,
  output logic [DIV_W-1:0]  cur_period_o
);

  logic [DIV_W-1:0]  cur_q, cur_d;
  logic [STEP_W-1:0] ramp_q, ramp_d;

  function automatic logic [DIV_W-1:0] sat_up(input logic [DIV_W-1:0] p);
    logic [DIV_W:0] sum;
    sum = {1'b0, p} + {1'b0, ACCEL_DEC};
    return (sum > {1'b0, START_PERIOD}) ? START_PERIOD : sum[DIV_W-1:0];
  endfunction

  function automatic logic [DIV_W-1:0] sat_down(input logic [DIV_W-1:0] p,
                                                input logic [DIV_W-1:0] floor_p);
    logic [DIV_W:0] lim;
    lim = {1'b0, floor_p} + {1'b0, ACCEL_DEC};
    return ({1'b0, p} > lim) ? (p - ACCEL_DEC) : floor_p;
  endfunction

  always_comb begin
    cur_d  = cur_q;
    ramp_d = ramp_q;
    if (load_i) begin
      cur_d  = (load_period_i > START_PERIOD) ? load_period_i : START_PERIOD;
      ramp_d = '0;
    end else if (step_i) begin
      // Start braking once the remaining steps no longer cover the ramp-down.
      if (rem_i <= ramp_q) begin
        cur_d = sat_up(cur_q);
        if (ramp_q != '0) ramp_d = ramp_q - STEP_W'(1);
      end else if (cur_q > period_l_i) begin
        cur_d  = sat_down(cur_q, period_l_i);
        ramp_d = ramp_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q  <= START_PERIOD;
      ramp_q <= '0;
    end else begin
      cur_q  <= cur_d;
      ramp_q <= ramp_d;
    end
  end

  assign cur_period_o = cur_q;

endmodule

// File: rtl/stepper_move.sv
// Single-axis stepper move engine: runs a counted, ramped move in full- or
// half-step mode in either direction, with limit-switch abort.
module stepper_move
  import stepper_pkg::*;
#(
  parameter int               STEP_W       = 12,
  parameter int               DIV_W        = 24,
  parameter logic [DIV_W-1:0] START_PERIOD = DIV_W'(DEF_START_PERIOD),
  parameter logic [DIV_W-1:0] ACCEL_DEC    = DIV_W'(DEF_ACCEL_DEC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              dir,
  input  logic              half_step,
  input  logic [STEP_W-1:0] steps,
  input  logic [DIV_W-1:0]  period,
  input  logic [3:0]        start_state,
  input  logic              boundary,
  output logic [3:0]        coil,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] steps_taken
);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [3:0]        coil_q, coil_d;
  logic [STEP_W-1:0] steps_l_q, steps_l_d, taken_q, taken_d;
  logic [DIV_W-1:0]  period_l_q, period_l_d, cnt_q, cnt_d;
  logic              dir_q, dir_d, half_q, half_d, aborted_q, aborted_d;

  logic [DIV_W-1:0]  cur_period, load_period;
  logic [STEP_W-1:0] rem, taken_inc;
  logic [2:0]        start_idx, step_idx, delta;
  logic              load, fire;

  assign load_period = (period == '0) ? DIV_W'(1) : period;
  assign start_idx   = pattern_to_index(start_state);
  assign taken_inc   = taken_q + STEP_W'(1);
  assign rem         = steps_l_q - taken_inc;
  assign load        = (state_q == LOAD) && go;
  // Boundary and a dropped go both outrank a step due in the same cycle.
  assign fire        = (state_q == RUN) && go && !boundary &&
                       (cnt_q == cur_period - DIV_W'(1));

  // Full-step from a single-coil phase moves one slot to realign.
  assign delta    = (half_q || !idx_q[0]) ? 3'd1 : 3'd2;
  assign step_idx = dir_q ? (idx_q + delta) : (idx_q - delta);

  step_ramp #(
    .STEP_W      (STEP_W),
    .DIV_W       (DIV_W),
    .START_PERIOD(START_PERIOD),
    .ACCEL_DEC   (ACCEL_DEC)
  ) u_ramp (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .load_period_i(load_period),
    .step_i       (fire),
    .rem_i        (rem),
    .period_l_i   (period_l_q),
    .cur_period_o (cur_period)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    coil_d     = coil_q;
    steps_l_d  = steps_l_q;
    taken_d    = taken_q;
    period_l_d = period_l_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    half_d     = half_q;
    aborted_d  = aborted_q;
    unique case (state_q)
      IDLE: if (go) state_d = LOAD;
      LOAD: begin
        if (!go) begin
          state_d = IDLE;
        end else begin
          steps_l_d  = steps;
          dir_d      = dir;
          half_d     = half_step;
          period_l_d = load_period;
          idx_d      = start_idx;
          coil_d     = PHASE_TABLE[start_idx];
          cnt_d      = '0;
          taken_d    = '0;
          aborted_d  = 1'b0;
          state_d    = (steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!go) begin
          state_d = IDLE;
        end else if (boundary) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (fire) begin
          cnt_d   = '0;
          taken_d = taken_inc;
          idx_d   = step_idx;
          coil_d  = PHASE_TABLE[step_idx];
          if (taken_inc == steps_l_q) state_d = DONE;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      DONE: if (!go) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd1;
      coil_q     <= RESET_COIL;
      steps_l_q  <= '0;
      taken_q    <= '0;
      period_l_q <= DIV_W'(1);
      cnt_q      <= '0;
      dir_q      <= 1'b1;
      half_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      coil_q     <= coil_d;
      steps_l_q  <= steps_l_d;
      taken_q    <= taken_d;
      period_l_q <= period_l_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      half_q     <= half_d;
      aborted_q  <= aborted_d;
    end
  end

  assign coil        = coil_q;
  assign busy        = (state_q == LOAD) || (state_q == RUN);
  assign done        = (state_q == DONE);
  assign aborted     = aborted_q;
  assign steps_taken = taken_q;

endmodule

// File: tb/tb_stepper_move.sv
// Scoreboard bench for stepper_move: a move-level model predicts every coil
// change, done and drop-to-idle event with its cycle offset from busy rising.
module tb_stepper_move;

  localparam int START_P = 20;
  localparam int DEC     = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0, dir = 1'b1, half_step = 1'b0, boundary = 1'b0;
  logic [7:0]  steps = '0;
  logic [15:0] period = '0;
  logic [3:0]  start_state = 4'b1100;
  logic [3:0]  coil;
  logic        busy, done, aborted;
  logic [7:0]  steps_taken;

  stepper_move #(
    .STEP_W      (8),
    .DIV_W       (16),
    .START_PERIOD(16'd20),
    .ACCEL_DEC   (16'd5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .dir        (dir),
    .half_step  (half_step),
    .steps      (steps),
    .period     (period),
    .start_state(start_state),
    .boundary   (boundary),
    .coil       (coil),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .steps_taken(steps_taken)
  );

  always #5 clk = ~clk;

  // kind: 0 = coil change, 1 = done rises, 2 = busy falls without done
  typedef struct {
    int       kind;
    int       off;
    logic [3:0] coil;
    int       taken;
    logic     ab;
  } ev_t;

  ev_t        exp_q[$];
  logic [3:0] ptab [0:7] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                             4'b0010, 4'b0011, 4'b0001, 4'b1001};
  logic [3:0] mod_coil = 4'b1100;
  int         mod_taken = 0;
  int         checks = 0, errors = 0;
  int         cyc = 0, t0 = 0;
  logic       mon_en = 1'b0;
  logic       prev_busy = 1'b0, prev_done = 1'b0;
  logic [3:0] prev_coil = 4'b1100;

  task automatic push_ev(input int kind, input int off, input logic [3:0] c,
                         input int taken, input logic ab);
    ev_t e;
    e.kind = kind; e.off = off; e.coil = c; e.taken = taken; e.ab = ab;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, expv);
    end
  endtask

  // mode 0 = full move, 1 = boundary abort at edge off, 2 = go dropped at edge off
  task automatic plan(input int n, input int p, input bit d, input bit h,
                      input logic [3:0] ss, input int mode, input int off,
                      output int end_off);
    int pe, cur, rc, t, idx, dl, stop, lo, hi;
    int st_t[$];
    logic [3:0] st_c[$];
    logic [3:0] start_coil;
    pe  = (p == 0) ? 1 : p;
    cur = (pe > START_P) ? pe : START_P;
    rc  = 0;
    t   = 1;
    idx = 1;
    for (int i = 0; i < 8; i++) if (ptab[i] == ss) idx = i;
    start_coil = ptab[idx];
    for (int k = 1; k <= n; k++) begin
      t += cur;
      dl  = h ? 1 : ((idx % 2 == 0) ? 1 : 2);
      idx = d ? (idx + dl) % 8 : (idx + 8 - dl) % 8;
      st_t.push_back(t);
      st_c.push_back(ptab[idx]);
      if (n - k <= rc) begin
        cur = (cur + DEC > START_P) ? START_P : cur + DEC;
        if (rc > 0) rc--;
      end else if (cur > pe) begin
        cur = (cur - DEC < pe) ? pe : cur - DEC;
        rc++;
      end
    end
    stop = 1 << 30;
    if (mode != 0) begin
      lo   = (mode == 1) ? 2 : 1;
      hi   = st_t[n-1];
      stop = (off > 0) ? off : lo + int'($urandom_range(0, hi - lo));
    end
    if (mode == 2 && stop == 1) begin
      push_ev(2, 1, mod_coil, mod_taken, 1'b0);
      end_off = 1;
      return;
    end
    if (start_coil != mod_coil) push_ev(0, 1, start_coil, 0, 1'b0);
    mod_coil  = start_coil;
    mod_taken = 0;
    end_off   = 1;
    for (int k = 0; k < n; k++) begin
      if (st_t[k] < stop) begin
        push_ev(0, st_t[k], st_c[k], k + 1, 1'b0);
        mod_coil  = st_c[k];
        mod_taken = k + 1;
        end_off   = st_t[k];
      end
    end
    if (mode == 0) begin
      push_ev(1, end_off, mod_coil, mod_taken, 1'b0);
    end else begin
      end_off = stop;
      push_ev((mode == 1) ? 1 : 2, stop, mod_coil, mod_taken, mode == 1);
    end
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d off=%0d coil=%b taken=%0d",
               kind, cyc - t0, coil, steps_taken);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.off != cyc - t0 || e.coil != coil ||
          e.taken != int'(steps_taken) || (kind == 1 && e.ab != aborted)) begin
        errors++;
        $display("FAIL event got kind=%0d off=%0d coil=%b taken=%0d ab=%b required kind=%0d off=%0d coil=%b taken=%0d ab=%b",
                 kind, cyc - t0, coil, steps_taken, aborted,
                 e.kind, e.off, e.coil, e.taken, e.ab);
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (busy && !prev_busy) t0 = cyc;
      if (coil != prev_coil) check_ev(0);
      if (done && !prev_done) check_ev(1);
      if (!busy && prev_busy && !done) check_ev(2);
    end
    prev_busy = busy;
    prev_done = done;
    prev_coil = coil;
  end

  task automatic run_move(input int n, input int p, input bit d, input bit h,
                          input logic [3:0] ss, input int mode, input int off);
    int eo;
    plan(n, p, d, h, ss, mode, off, eo);
    @(posedge clk); #1;
    steps = 8'(n); period = 16'(p); dir = d; half_step = h; start_state = ss;
    go = 1'b1;
    for (int e = 0; e < eo; e++) begin
      @(posedge clk); #1;
      if (mode == 1 && e + 1 == eo) boundary = 1'b1;
      if (mode == 2 && e + 1 == eo) go = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pending_events", exp_q.size(), 0);
    exp_q.delete();
    go = 1'b0;
    boundary = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_move();
    int eo;
    plan(12, 5, 1'b1, 1'b0, 4'b0011, 0, 0, eo);
    @(posedge clk); #1;
    steps = 8'd12; period = 16'd5; dir = 1'b1; half_step = 1'b0;
    start_state = 4'b0011;
    go = 1'b1;
    repeat (30) @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_coil", int'(coil), 4'b1100);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_done", int'(done), 0);
    chk("rst_async_aborted", int'(aborted), 0);
    chk("rst_async_taken", int'(steps_taken), 0);
    exp_q.delete();
    go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mod_coil  = 4'b1100;
    mod_taken = 0;
    @(negedge clk);
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p, mode;
    logic [3:0] ss;
    #12;
    chk("reset_coil", int'(coil), 4'b1100);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_aborted", int'(aborted), 0);
    chk("reset_taken", int'(steps_taken), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    mon_en = 1'b1;

    run_move(4, 10, 1'b1, 1'b0, 4'b1100, 0, 0);
    run_move(3, 10, 1'b0, 1'b1, 4'b1100, 0, 0);
    run_move(2, 10, 1'b1, 1'b0, 4'b0100, 0, 0);
    run_move(10, 10, 1'b1, 1'b0, 4'b1100, 1, 37);
    run_move(10, 10, 1'b1, 1'b1, 4'b1100, 1, 46);
    run_move(0, 7, 1'b1, 1'b0, mod_coil, 0, 0);
    run_move(8, 10, 1'b0, 1'b0, 4'b1001, 2, 40);
    run_move(5, 10, 1'b1, 1'b0, 4'b0011, 2, 1);
    reset_mid_move();
    run_move(5, 3, 1'b1, 1'b1, 4'b1111, 0, 0);
    run_move(6, 0, 1'b0, 1'b0, 4'b0010, 0, 0);

    for (int i = 0; i < 30; i++) begin
      n  = int'($urandom_range(0, 12));
      p  = int'($urandom_range(0, 20));
      ss = ($urandom_range(0, 3) != 0) ? ptab[$urandom_range(0, 7)]
                                       : 4'($urandom);
      mode = int'($urandom_range(0, 4));
      if (mode > 2 || n == 0) mode = 0;
      run_move(n, p, 1'($urandom), 1'($urandom), ss, mode, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
